// File: rtl/prog_mem_loader.sv
// Byte-stream loader: packs LSB-first bytes into 32-bit words, writes IM/DM, drives CPU start.
// Write strobe one cycle after the 4th data byte; rx_ready_o drops only for that write cycle.
module prog_mem_loader #(
    parameter int CNT_W  = 8,
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_valid_i,
    output logic              rx_ready_o,
    output logic              im_we_o,
    output logic              dm_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_data_o,
    output logic              cpu_start_o,
    output logic              busy_o,
    output logic              err_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CNT   = 3'd1,
        S_ADDR  = 3'd2,
        S_DATA  = 3'd3,
        S_WRITE = 3'd4
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] words_left;
    logic [CNT_W-1:0] word_addr;
    logic [1:0]       byte_cnt;
    logic [31:0]      asm_word;
    logic             to_dm;
    logic             xfer;

    assign xfer   = rx_valid_i & rx_ready_o;
    assign busy_o = (state != S_IDLE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            words_left  <= '0;
            word_addr   <= '0;
            byte_cnt    <= '0;
            asm_word    <= '0;
            to_dm       <= 1'b0;
            rx_ready_o  <= 1'b0;
            im_we_o     <= 1'b0;
            dm_we_o     <= 1'b0;
            mem_addr_o  <= '0;
            mem_data_o  <= '0;
            cpu_start_o <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            rx_ready_o <= 1'b1;
            im_we_o    <= 1'b0;
            dm_we_o    <= 1'b0;
            case (state)
                S_IDLE: if (xfer) begin
                    if (rx_data_i[5:0] != 6'd0) begin
                        err_o <= 1'b1;
                    end else begin
                        case (rx_data_i[7:6])
                            2'b00, 2'b01: begin
                                to_dm       <= rx_data_i[6];
                                cpu_start_o <= 1'b0;
                                state       <= S_CNT;
                            end
                            2'b10:   cpu_start_o <= 1'b1;
                            default: cpu_start_o <= 1'b0;
                        endcase
                    end
                end
                S_CNT: if (xfer) begin
                    words_left <= CNT_W'(rx_data_i);
                    state      <= S_ADDR;
                end
                S_ADDR: if (xfer) begin
                    word_addr <= CNT_W'(rx_data_i);
                    byte_cnt  <= 2'd0;
                    state     <= (words_left == '0) ? S_IDLE : S_DATA;
                end
                S_DATA: if (xfer) begin
                    // Shift right so the first byte ends up in bits [7:0].
                    asm_word <= {rx_data_i, asm_word[31:8]};
                    byte_cnt <= byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3) begin
                        im_we_o    <= ~to_dm;
                        dm_we_o    <= to_dm;
                        mem_addr_o <= ADDR_W'({word_addr, 2'b00});
                        mem_data_o <= {rx_data_i, asm_word[31:8]};
                        rx_ready_o <= 1'b0;
                        state      <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    word_addr  <= word_addr + 1'b1;
                    words_left <= words_left - 1'b1;
                    state      <= (words_left == CNT_W'(1)) ? S_IDLE : S_DATA;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_mem_loader.sv
// Directed frames for prog_mem_loader; expected memory writes are queued and checked by a monitor.
module tb_prog_mem_loader;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready_o;
    logic        im_we_o;
    logic        dm_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic        cpu_start_o;
    logic        busy_o;
    logic        err_o;

    typedef struct packed {
        logic        dm;
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  writes = 0;

    prog_mem_loader #(.CNT_W(8), .ADDR_W(32)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .rx_data_i   (rx_data),
        .rx_valid_i  (rx_valid),
        .rx_ready_o  (rx_ready_o),
        .im_we_o     (im_we_o),
        .dm_we_o     (dm_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_data_o  (mem_data_o),
        .cpu_start_o (cpu_start_o),
        .busy_o      (busy_o),
        .err_o       (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && (im_we_o || dm_we_o)) begin
            wr_t w;
            writes++;
            checks++;
            if (im_we_o && dm_we_o) begin
                errors++;
                $display("FAIL both_strobes: im %b dm %b expected one", im_we_o, dm_we_o);
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: dm %b addr %h data %h expected none",
                         dm_we_o, mem_addr_o, mem_data_o);
            end else begin
                w = exp_q.pop_front();
                if (dm_we_o !== w.dm || mem_addr_o !== w.addr || mem_data_o !== w.data) begin
                    errors++;
                    $display("FAIL write: got dm %b addr %h data %h expected dm %b addr %h data %h",
                             dm_we_o, mem_addr_o, mem_data_o, w.dm, w.addr, w.data);
                end
            end
            chk("ready_low_in_write", {31'd0, rx_ready_o}, 32'd0);
        end
    end

    task automatic send(input logic [7:0] b);
        int t;
        t = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        while (!rx_ready_o && t < 50) begin
            t++;
            @(posedge clk);
        end
        if (t >= 50) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: byte %h not accepted after %0d cycles, expected accept", b, t);
        end
        #1 rx_valid = 1'b0;
    endtask

    task automatic send_list(input logic [7:0] bytes[$]);
        foreach (bytes[i]) send(bytes[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;

        // 1: reset
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, rx_ready_o}, 32'd0);
        chk("rst_strobes", {30'd0, im_we_o, dm_we_o}, 32'd0);
        chk("rst_addr", mem_addr_o, 32'd0);
        chk("rst_data", mem_data_o, 32'd0);
        chk("rst_start_busy_err", {29'd0, cpu_start_o, busy_o, err_o}, 32'd0);
        rst = 1'b0;
        idle(1);
        chk("post_rst_ready", {31'd0, rx_ready_o}, 32'd1);
        chk("post_rst_busy", {31'd0, busy_o}, 32'd0);

        // 2: single IM word
        exp_q.push_back('{dm: 1'b0, addr: 32'd0, data: 32'h12345678});
        send_list('{8'h00, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12});
        chk("t2_busy_in_write", {31'd0, busy_o}, 32'd1);
        idle(3);
        chk("t2_idle", {31'd0, busy_o}, 32'd0);
        chk("t2_start", {31'd0, cpu_start_o}, 32'd0);
        chk("t2_hold_data", mem_data_o, 32'h12345678);

        // 3: DM, address wrap 255 -> 0, with a gap mid-word
        exp_q.push_back('{dm: 1'b1, addr: 32'd1020, data: 32'd1});
        exp_q.push_back('{dm: 1'b1, addr: 32'd0, data: 32'd2});
        send_list('{8'h40, 8'h02, 8'hFF, 8'h01, 8'h00});
        idle(4);
        send_list('{8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00});
        idle(3);
        chk("t3_idle", {31'd0, busy_o}, 32'd0);

        // 4: RUN, then LOAD with N=0
        send(8'h80);
        chk("t4_run", {31'd0, cpu_start_o}, 32'd1);
        send(8'h00);
        chk("t4_load_stops", {31'd0, cpu_start_o}, 32'd0);
        chk("t4_busy", {31'd0, busy_o}, 32'd1);
        send_list('{8'h00, 8'h05});
        chk("t4_n0_idle", {31'd0, busy_o}, 32'd0);
        idle(2);

        // 5: bad header, then HALT
        send(8'h80);
        chk("t5_run", {31'd0, cpu_start_o}, 32'd1);
        send(8'h41);
        chk("t5_err", {31'd0, err_o}, 32'd1);
        chk("t5_no_state", {30'd0, busy_o, cpu_start_o}, 32'd1);
        send(8'hC0);
        chk("t5_halt", {31'd0, cpu_start_o}, 32'd0);
        chk("t5_err_sticky", {31'd0, err_o}, 32'd1);

        // 6: reset mid-frame, then a clean frame
        send(8'h80);
        send_list('{8'h40, 8'h01, 8'h10, 8'hAA, 8'hBB});
        rst = 1'b1;
        idle(1);
        chk("t6_rst_busy_start_err", {29'd0, busy_o, cpu_start_o, err_o}, 32'd0);
        chk("t6_rst_ready", {31'd0, rx_ready_o}, 32'd0);
        rst = 1'b0;
        idle(1);
        exp_q.push_back('{dm: 1'b1, addr: 32'd64, data: 32'h44332211});
        send_list('{8'h40, 8'h01, 8'h10, 8'h11, 8'h22, 8'h33, 8'h44});
        idle(4);

        chk("write_count", writes, 32'd4);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1);
    end

endmodule
